// File: rtl/sa_pkg.sv
// Shared types and helpers for the parametrised systolic array.
// Tiles are packed row-major, with element (row, col) at bit (row*dim + col) * width.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_CAPT = 2'd2
    } sa_state_e;

    // Number of cycles needed to push a full skewed tile through a dim x dim grid.
    function automatic int feed_len(input int dim);
        return 3 * dim - 2;
    endfunction

    function automatic int tile_idx(input int dim, input int row, input int col);
        return row * dim + col;
    endfunction

    function automatic int tile_lsb(input int dim, input int width, input int row, input int col);
        return tile_idx(dim, row, col) * width;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC cell.
// Operands travel east and south; the running sum stays in the cell.
module sa_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              sa_rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] west_in,
    input  logic [DATA_W-1:0] north_in,
    output logic [DATA_W-1:0] east_out,
    output logic [DATA_W-1:0] south_out,
    output logic [ACC_W-1:0]  acc
);

    localparam int PW = 2 * DATA_W + 2;

    logic [DATA_W-1:0] east_q, east_d, south_q, south_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PW-1:0] w_x, n_x, prod;

    always_comb begin
        // Sign or zero extension is chosen per tile; the product is exact in PW bits.
        w_x     = {{(PW-DATA_W){signed_mode & west_in[DATA_W-1]}}, west_in};
        n_x     = {{(PW-DATA_W){signed_mode & north_in[DATA_W-1]}}, north_in};
        prod    = w_x * n_x;
        acc_d   = acc_q;
        east_d  = '0;
        south_d = '0;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d   = acc_q + ACC_W'(prod);
            east_d  = west_in;
            south_d = north_in;
        end
    end

    always_ff @(posedge clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
            east_q  <= '0;
            south_q <= '0;
            acc_q   <= '0;
        end else begin
            east_q  <= east_d;
            south_q <= south_d;
            acc_q   <= acc_d;
        end
    end

    assign east_out  = east_q;
    assign south_out = south_q;
    assign acc       = acc_q;

endmodule

// File: rtl/systolic_array_param.sv
// DIM x DIM output-stationary systolic array: skew generator, sequencing FSM and PE grid.
//   state   | meaning
//   ST_IDLE | waiting for start; tiles latched and accumulators optionally cleared on accept
//   ST_FEED | skewed operands streamed into the grid, cnt = 0 .. 3*DIM-3
//   ST_CAPT | accumulators copied to c_tile; done pulses in the following cycle
module systolic_array_param
    import sa_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 6
) (
    input  logic                      clk,
    input  logic                      sa_rst_n,
    input  logic                      start,
    input  logic                      acc_mode,
    input  logic                      signed_mode,
    input  logic [DIM*DIM*DATA_W-1:0] a_tile,
    input  logic [DIM*DIM*DATA_W-1:0] b_tile,
    output logic                      busy,
    output logic                      done,
    output logic [DIM*DIM*ACC_W-1:0]  c_tile
);

    localparam int LAST_CNT = feed_len(DIM) - 1;

    sa_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIM*DIM*DATA_W-1:0] a_q, b_q;
    logic                      sgn_q, done_q;
    logic [DIM*DIM*ACC_W-1:0]  c_q, acc_flat;
    logic                      accept, pe_en, pe_clr;

    logic [DATA_W-1:0] west_edge  [DIM];
    logic [DATA_W-1:0] north_edge [DIM];
    logic [DATA_W-1:0] h_bus [DIM][DIM+1];
    logic [DATA_W-1:0] v_bus [DIM+1][DIM];

    assign accept = (state_q == ST_IDLE) && start;
    assign pe_en  = (state_q == ST_FEED);
    assign pe_clr = accept && !acc_mode;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FEED;
                    cnt_d   = '0;
                end
            end
            ST_FEED: begin
                if (cnt_q == CNT_W'(LAST_CNT)) state_d = ST_CAPT;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            ST_CAPT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == ST_CAPT);
            if (accept) begin
                a_q   <= a_tile;
                b_q   <= b_tile;
                sgn_q <= signed_mode;
            end
            if (state_q == ST_CAPT) c_q <= acc_flat;
        end
    end

    // Row i / column j lag the counter by i / j cycles so that A[i][k] meets B[k][j] in PE(i,j).
    always_comb begin
        int k;
        for (int i = 0; i < DIM; i++) begin
            west_edge[i]  = '0;
            north_edge[i] = '0;
            k = int'(cnt_q) - i;
            if (k >= 0 && k < DIM) begin
                west_edge[i]  = a_q[tile_lsb(DIM, DATA_W, i, k) +: DATA_W];
                north_edge[i] = b_q[tile_lsb(DIM, DATA_W, k, i) +: DATA_W];
            end
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        assign h_bus[gi][0] = west_edge[gi];
        assign v_bus[0][gi] = north_edge[gi];
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            sa_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk         (clk),
                .sa_rst_n    (sa_rst_n),
                .en          (pe_en),
                .clr         (pe_clr),
                .signed_mode (sgn_q),
                .west_in     (h_bus[gi][gj]),
                .north_in    (v_bus[gi][gj]),
                .east_out    (h_bus[gi][gj+1]),
                .south_out   (v_bus[gi+1][gj]),
                .acc         (acc_flat[tile_lsb(DIM, ACC_W, gi, gj) +: ACC_W])
            );
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign c_tile = c_q;

endmodule

// File: tb/tb_systolic_array_param.sv
// Directed bench for systolic_array_param: table of DIM=4 tiles, handshake/reset sequences,
// and DIM=2 / DIM=8 wide-operand sweeps against a software matrix product.
module tb_systolic_array_param;

    localparam int D   = 4;
    localparam int W   = 8;
    localparam int AW4 = 32;
    localparam int DM  = 8;
    localparam int DW  = 16;
    localparam int AW  = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  start4, am4, sm4, busy4, done4;
    logic [D*D*W-1:0]      a4, b4;
    logic [D*D*AW4-1:0]    c4;
    logic                  start2, sm2, busy2, done2;
    logic [2*2*DW-1:0]     a2, b2;
    logic [2*2*AW-1:0]     c2;
    logic                  start8, sm8, busy8, done8;
    logic [DM*DM*DW-1:0]   a8, b8;
    logic [DM*DM*AW-1:0]   c8;
    logic                  am_sweep;

    int n_vec = 0;
    int n_err = 0;

    systolic_array_param #(.DIM(D), .DATA_W(W), .ACC_W(AW4), .CNT_W(6)) u4 (
        .clk(clk), .sa_rst_n(rst_n), .start(start4), .acc_mode(am4), .signed_mode(sm4),
        .a_tile(a4), .b_tile(b4), .busy(busy4), .done(done4), .c_tile(c4));

    systolic_array_param #(.DIM(2), .DATA_W(DW), .ACC_W(AW), .CNT_W(6)) u2 (
        .clk(clk), .sa_rst_n(rst_n), .start(start2), .acc_mode(am_sweep), .signed_mode(sm2),
        .a_tile(a2), .b_tile(b2), .busy(busy2), .done(done2), .c_tile(c2));

    systolic_array_param #(.DIM(DM), .DATA_W(DW), .ACC_W(AW), .CNT_W(6)) u8 (
        .clk(clk), .sa_rst_n(rst_n), .start(start8), .acc_mode(am_sweep), .signed_mode(sm8),
        .a_tile(a8), .b_tile(b8), .busy(busy8), .done(done8), .c_tile(c8));

    typedef struct {
        logic               am;
        logic               sm;
        logic [D*D*W-1:0]   a;
        logic [D*D*W-1:0]   b;
        logic [D*D*AW4-1:0] c;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tile4(input string name, input logic [D*D*AW4-1:0] exp);
        bit bad;
        bad = 1'b0;
        n_vec++;
        for (int e = 0; e < D*D; e++) begin
            if (!bad && c4[e*AW4 +: AW4] !== exp[e*AW4 +: AW4]) begin
                bad = 1'b1;
                n_err++;
                $display("FAIL %s: element %0d got %h expected %h", name, e,
                         c4[e*AW4 +: AW4], exp[e*AW4 +: AW4]);
            end
        end
    endtask

    function automatic logic [D*D*W-1:0] rep8(input logic [W-1:0] v);
        logic [D*D*W-1:0] r;
        for (int e = 0; e < D*D; e++) r[e*W +: W] = v;
        return r;
    endfunction

    function automatic logic [D*D*AW4-1:0] rep32(input logic [AW4-1:0] v);
        logic [D*D*AW4-1:0] r;
        for (int e = 0; e < D*D; e++) r[e*AW4 +: AW4] = v;
        return r;
    endfunction

    // Caller is at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic run4(input logic am, input logic sm, input logic [D*D*W-1:0] a,
                        input logic [D*D*W-1:0] b, output int lat, output int nbusy);
        start4 = 1'b1; am4 = am; sm4 = sm; a4 = a; b4 = b;
        @(posedge clk); #1;
        start4 = 1'b0; am4 = ~am; sm4 = ~sm;
        a4 = {$urandom, $urandom, $urandom, $urandom};
        b4 = {$urandom, $urandom, $urandom, $urandom};
        lat = 0; nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy4) nbusy++;
        end while (!done4 && lat < 60);
    endtask

    task automatic run_sweep(input int dim, input logic sm);
        logic [DM*DM*DW-1:0] a, b;
        logic [DM*DM*AW-1:0] exp, got;
        longint s, x, y;
        int lat;
        bit bad;
        a = '0; b = '0; exp = '0; got = '0;
        for (int e = 0; e < dim*dim; e++) begin
            a[e*DW +: DW] = DW'($urandom);
            b[e*DW +: DW] = DW'($urandom);
        end
        for (int i = 0; i < dim; i++)
            for (int j = 0; j < dim; j++) begin
                s = 0;
                for (int k = 0; k < dim; k++) begin
                    x = sm ? longint'($signed(a[(i*dim+k)*DW +: DW])) : longint'(a[(i*dim+k)*DW +: DW]);
                    y = sm ? longint'($signed(b[(k*dim+j)*DW +: DW])) : longint'(b[(k*dim+j)*DW +: DW]);
                    s = s + x * y;
                end
                exp[(i*dim+j)*AW +: AW] = s[AW-1:0];
            end
        @(negedge clk);
        if (dim == 2) begin
            start2 = 1'b1; sm2 = sm; a2 = a[2*2*DW-1:0]; b2 = b[2*2*DW-1:0];
        end else begin
            start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        end
        @(posedge clk); #1;
        start2 = 1'b0; start8 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!((dim == 2) ? done2 : done8) && lat < 100);
        chk($sformatf("sweep dim%0d latency", dim), lat, 3*dim);
        if (dim == 2) got[2*2*AW-1:0] = c2;
        else          got = c8;
        bad = 1'b0;
        n_vec++;
        for (int e = 0; e < dim*dim; e++) begin
            if (!bad && got[e*AW +: AW] !== exp[e*AW +: AW]) begin
                bad = 1'b1;
                n_err++;
                $display("FAIL sweep dim%0d signed=%0d: element %0d got %h expected %h",
                         dim, sm, e, got[e*AW +: AW], exp[e*AW +: AW]);
            end
        end
    endtask

    initial begin
        logic [D*D*W-1:0]   ident, bseq;
        logic [D*D*AW4-1:0] cseq;
        int lat, nbusy, ndone, first_done;

        ident = '0;
        for (int i = 0; i < D; i++) ident[(i*D+i)*W +: W] = 8'd1;
        for (int e = 0; e < D*D; e++) begin
            bseq[e*W +: W]   = W'(e + 1);
            cseq[e*AW4 +: AW4] = AW4'(e + 1);
        end
        vecs[0] = '{am: 1'b0, sm: 1'b0, a: ident,      b: bseq,       c: cseq};
        vecs[1] = '{am: 1'b0, sm: 1'b1, a: rep8(8'hFF), b: rep8(8'h02), c: rep32(32'hFFFF_FFF8)};
        vecs[2] = '{am: 1'b0, sm: 1'b0, a: rep8(8'hFF), b: rep8(8'h02), c: rep32(32'd2040)};
        vecs[3] = '{am: 1'b0, sm: 1'b0, a: rep8(8'h01), b: rep8(8'h01), c: rep32(32'd4)};
        vecs[4] = '{am: 1'b1, sm: 1'b0, a: rep8(8'h01), b: rep8(8'h01), c: rep32(32'd8)};

        rst_n = 1'b0;
        start4 = 1'b0; am4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        am_sweep = 1'b0;

        #12;
        chk_tile4("reset c_tile", '0);
        chk("reset busy", busy4, 0);
        chk("reset done", done4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            run4(vecs[v].am, vecs[v].sm, vecs[v].a, vecs[v].b, lat, nbusy);
            chk($sformatf("vec%0d latency", v), lat, 12);
            chk($sformatf("vec%0d busy cycles", v), nbusy, 11);
            chk_tile4($sformatf("vec%0d c_tile", v), vecs[v].c);
        end

        // Start issued in the done cycle of the previous tile.
        run4(1'b0, 1'b0, ident, bseq, lat, nbusy);
        chk("start in done cycle latency", lat, 12);
        chk_tile4("start in done cycle c_tile", cseq);

        // Start pulse during FEED (cnt = 3) must be ignored.
        @(negedge clk);
        start4 = 1'b1; am4 = 1'b0; sm4 = 1'b0; a4 = rep8(8'h01); b4 = rep8(8'h01);
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0; ndone = 0; first_done = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                start4 = 1'b1; a4 = rep8(8'h02); b4 = rep8(8'h03);
            end
            if (lat == 5) start4 = 1'b0;
            if (done4) begin
                ndone++;
                if (first_done == 0) first_done = lat;
            end
        end
        chk("busy start done count", ndone, 1);
        chk("busy start latency", first_done, 12);
        chk_tile4("busy start c_tile", rep32(32'd4));

        // Reset asserted at FEED cnt = 5.
        @(negedge clk);
        start4 = 1'b1; am4 = 1'b0; sm4 = 1'b0; a4 = rep8(8'hFF); b4 = rep8(8'h02);
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int n = 0; n < 6; n++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_tile4("mid-feed reset c_tile", '0);
        chk("mid-feed reset busy", busy4, 0);
        chk("mid-feed reset done", done4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        chk("no done after reset", ndone, 0);
        run4(1'b1, 1'b0, rep8(8'h01), rep8(8'h01), lat, nbusy);
        chk("post-reset latency", lat, 12);
        chk_tile4("post-reset accumulate onto zero", rep32(32'd4));

        run_sweep(2, 1'b1);
        run_sweep(2, 1'b1);
        run_sweep(DM, 1'b1);
        run_sweep(DM, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_array_param.md
Name: systolic_array_param

Overview:
- Parametrised successor of the fixed 4x4 byte systolic array: DIM x DIM output-stationary MAC grid with configurable operand width, accumulator width and signed/unsigned mode.
- Computes C = A x B on one DIM x DIM tile per start, with an optional accumulate-across-tiles mode for K > DIM.
- Uses a start/busy/done handshake and an internal skew generator.
- Sits inside the user project between the local A/B/C buffers and the control FSM.

Parameters:
- DIM, 4, array edge; number of rows, columns and tile depth. Range 2..16.
- DATA_W, 8, operand width of A and B elements.
- ACC_W, 32, accumulator/result width. Must be >= 2*DATA_W + clog2(DIM).
- CNT_W, 6, phase counter width. Must be >= clog2(3*DIM).

Ports:
- clk, in, 1, single clock; all state changes on posedge.
- sa_rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request one tile; sampled only in IDLE.
- acc_mode, in, 1, latched at start. 0 = clear accumulators first; 1 = add onto the previous C.
- signed_mode, in, 1, latched at start. 1 = two's-complement operands; 0 = unsigned.
- a_tile, in, DIM*DIM*DATA_W, A[i][k] at bits [(i*DIM+k)*DATA_W +: DATA_W]; latched at start.
- b_tile, in, DIM*DIM*DATA_W, B[k][j] at bits [(k*DIM+j)*DATA_W +: DATA_W]; latched at start.
- busy, out, 1, high from the cycle after start is accepted through CAPT.
- done, out, 1, one-cycle pulse when c_tile is updated.
- c_tile, out, DIM*DIM*ACC_W, C[i][j] at bits [(i*DIM+j)*ACC_W +: ACC_W]; held until the next CAPT.

Behaviour:
- Reset (async, sa_rst_n low): state IDLE, busy 0, done 0, c_tile 0, all PE accumulators and pipeline registers 0, counter 0, latched tiles 0.
- States and transitions:
  - IDLE: start=1 latches a_tile, b_tile, acc_mode and signed_mode. Clears all PE east/south pipeline registers. Clears accumulators if acc_mode=0, keeps them if acc_mode=1. cnt <= 0; go to FEED.
  - FEED: lasts exactly 3*DIM-2 cycles, cnt = 0..3*DIM-3, then go to CAPT.
    - West input row i = A[i][cnt-i] when 0 <= cnt-i < DIM, else 0.
    - North input column j = B[cnt-j][j] when 0 <= cnt-j < DIM, else 0.
    - PE enable is high only in FEED.
  - CAPT: one cycle. c_tile <= all accumulators; PE disabled; go to IDLE. done=1 is registered and visible in the following cycle (the first IDLE cycle).
- Latency: start sampled at edge 0 -> done high for the cycle after edge 3*DIM. For DIM=4 that is 12 cycles. busy low in the done cycle.
- PE(i,j) per enabled cycle: east <= west_in, south <= north_in, acc <= acc + ext(west_in)*ext(north_in).
  - ext is sign- or zero-extension to ACC_W per the latched signed_mode.
  - Product is 2*DATA_W bits, extended to ACC_W; sum wraps modulo 2^ACC_W with no saturation.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start in the done cycle: accepted, since the state is IDLE.
  - Input tile changes during FEED or CAPT: no effect.
  - acc_mode=1 on the first tile after reset: accumulates onto 0.
  - Reset mid-FEED: immediate clear; no done pulse; c_tile is 0.
  - Inputs entering the east/south edges of the grid are discarded.

Decomposition:
- Package sa_pkg:
  - state encoding IDLE/FEED/CAPT (2 bits);
  - function computing the FEED length (3*DIM-2);
  - index helper functions for the tile packing.
- One sub-module sa_pe: single MAC cell with ports clk, sa_rst_n, en, clr, signed_mode, west_in, north_in, east_out, south_out, acc. Generated DIM*DIM times.
- The skew generator and FSM stay in the top module.

Test Plan:
- DIM=4, unsigned, A = identity, B[k][j] = 4k+j+1, start -> done exactly 12 cycles after the start edge; C = B; busy high for 11 cycles.
- DIM=4, signed, all A = 8'hFF (-1), all B = 8'h02 -> every C element = 32'hFFFF_FFF8 (-8). Same data with unsigned -> every element = 2040.
- Accumulate: tile1 all-ones A/B with acc_mode=0 -> C = 4 everywhere; tile2 same data with acc_mode=1 -> C = 8 everywhere.
- Reset handling: assert sa_rst_n=0 at FEED cnt=5 -> c_tile, busy and done all 0 immediately; a fresh start after release gives correct results with no residue.
- Handshake: pulse start at cnt=3 of FEED -> ignored and exactly one done. Start asserted in the done cycle -> accepted; second done 12 cycles later.
- Parameter sweep: DIM=2 and DIM=8 with DATA_W=16 and ACC_W=40, random signed tiles -> matches the reference model modulo 2^ACC_W; done at 3*DIM cycles.
